// File: rtl/clock_reset_sequencer.sv
// Brings chained clock managers out of reset one stage at a time, waits for each
// to lock and settle, then releases the user-logic reset. Lock loss restarts the chain.
module clock_reset_sequencer #(
  parameter int Channels     = 2,
  parameter int HoldCycles   = 4,
  parameter int LockTimeout  = 4096,
  parameter int SettleCycles = 16,
  parameter int MaxRetries   = 3,
  localparam int CW = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [Channels-1:0] locked,
  output logic [Channels-1:0] cm_reset,
  output logic                sys_reset,
  output logic                ready,
  output logic                fault,
  output logic [CW-1:0]       fault_chan,
  output logic [CW-1:0]       stage,
  output logic [7:0]          loss_count
);

  localparam int TMAX0 = (HoldCycles > SettleCycles) ? HoldCycles : SettleCycles;
  localparam int TMAX  = (TMAX0 > LockTimeout) ? TMAX0 : LockTimeout;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW    = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HoldCycles - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LockTimeout - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SettleCycles - 1);
  localparam logic [CW-1:0] LAST_CH     = CW'(Channels - 1);

  typedef enum logic [2:0] {HOLD, WAIT_LOCK, SETTLE, RUN, FAULT} state_e;

  state_e                state_q, state_d;
  logic [Channels-1:0]   sync1_q, lsync_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RW-1:0]         retries_q, retries_d;
  logic [Channels-1:0]   cm_reset_q, cm_reset_d;
  logic                  sys_reset_q, sys_reset_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic [CW-1:0]         fault_chan_q, fault_chan_d;
  logic [CW-1:0]         stage_q, stage_d;
  logic [7:0]            loss_q, loss_d;
  logic                  casc;
  logic [CW-1:0]         casc_k;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retries_d    = retries_q;
    cm_reset_d   = cm_reset_q;
    sys_reset_d  = sys_reset_q;
    ready_d      = ready_q;
    fault_d      = fault_q;
    fault_chan_d = fault_chan_q;
    stage_d      = stage_q;
    loss_d       = loss_q;

    // Lowest already-released channel that lost lock; in RUN every channel counts.
    casc   = 1'b0;
    casc_k = '0;
    for (int k = Channels - 1; k >= 0; k--) begin
      if (!lsync_q[k] && ((state_q == RUN) ||
          ((state_q == WAIT_LOCK || state_q == SETTLE) && k < int'(stage_q)))) begin
        casc   = 1'b1;
        casc_k = CW'(k);
      end
    end

    if (casc) begin
      for (int j = 0; j < Channels; j++) begin
        if (j >= int'(casc_k)) cm_reset_d[j] = 1'b0;
      end
      stage_d     = casc_k;
      retries_d   = '0;
      sys_reset_d = 1'b0;
      ready_d     = 1'b0;
      timer_d     = '0;
      state_d     = HOLD;
      if (state_q == RUN && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (timer_q == HOLD_LAST) begin
            cm_reset_d[stage_q] = 1'b1;
            timer_d             = '0;
            state_d             = WAIT_LOCK;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lsync_q[stage_q]) begin
            timer_d = '0;
            state_d = SETTLE;
          end else if (timer_q == TO_LAST) begin
            timer_d = '0;
            if (int'(retries_q) < MaxRetries) begin
              cm_reset_d[stage_q] = 1'b0;
              retries_d           = retries_q + 1'b1;
              state_d             = HOLD;
            end else begin
              for (int j = 0; j < Channels; j++) begin
                if (j >= int'(stage_q)) cm_reset_d[j] = 1'b0;
              end
              fault_d      = 1'b1;
              fault_chan_d = stage_q;
              sys_reset_d  = 1'b0;
              ready_d      = 1'b0;
              state_d      = FAULT;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        SETTLE: begin
          if (!lsync_q[stage_q]) begin
            cm_reset_d[stage_q] = 1'b0;
            timer_d             = '0;
            state_d             = HOLD;
          end else if (timer_q == SETTLE_LAST) begin
            timer_d = '0;
            if (stage_q == LAST_CH) begin
              sys_reset_d = 1'b1;
              ready_d     = 1'b1;
              state_d     = RUN;
            end else begin
              stage_d   = stage_q + 1'b1;
              retries_d = '0;
              state_d   = HOLD;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RUN:     ;
        FAULT:   ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= HOLD;
      sync1_q      <= '0;
      lsync_q      <= '0;
      timer_q      <= '0;
      retries_q    <= '0;
      cm_reset_q   <= '0;
      sys_reset_q  <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_chan_q <= '0;
      stage_q      <= '0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= locked;
      lsync_q      <= sync1_q;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      cm_reset_q   <= cm_reset_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      fault_chan_q <= fault_chan_d;
      stage_q      <= stage_d;
      loss_q       <= loss_d;
    end
  end

  assign cm_reset   = cm_reset_q;
  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign fault_chan = fault_chan_q;
  assign stage      = stage_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer with Channels=2, HoldCycles=4,
// SettleCycles=16, LockTimeout=64, MaxRetries=1; edge n is the n-th edge after release.
module tb_clock_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] locked;
  logic [1:0] cm_reset;
  logic       sys_reset, ready, fault;
  logic       fault_chan, stage;
  logic [7:0] loss_count;
  logic [6:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  always #5 clock = ~clock;

  clock_reset_sequencer #(
    .Channels(2), .HoldCycles(4), .LockTimeout(64), .SettleCycles(16), .MaxRetries(1)
  ) dut (
    .clock(clock), .reset(reset), .locked(locked), .cm_reset(cm_reset),
    .sys_reset(sys_reset), .ready(ready), .fault(fault), .fault_chan(fault_chan),
    .stage(stage), .loss_count(loss_count)
  );

  // {cm_reset[1:0], sys_reset, ready, fault, fault_chan, stage}
  assign obs = {cm_reset, sys_reset, ready, fault, fault_chan, stage};

  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clock);
      edge_n++;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    locked = 2'b00;
    #2;
    tests_run++;
    if (obs !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL rst_outputs obs=%b exp=%b", obs, 7'b0000000);
    end
    tests_run++;
    if (loss_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_loss got=%0d exp=0", loss_count);
    end
    @(negedge clock);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic bring_up();
    apply_reset();
    step_to(13); locked = 2'b01;
    step_to(45); locked = 2'b11;
    step_to(64);
  endtask

  task automatic test_nominal(input string tag);
    apply_reset();
    step_to(3);
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL %s_e3 obs=%b exp=%b", tag, obs, 7'b0000000); end
    step_to(4);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL %s_e4 obs=%b exp=%b", tag, obs, 7'b0100000); end
    step_to(13); locked = 2'b01;
    step_to(31);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL %s_e31 obs=%b exp=%b", tag, obs, 7'b0100000); end
    step_to(35);
    tests_run++;
    if (obs !== 7'b0100001) begin tests_failed++; $display("FAIL %s_e35 obs=%b exp=%b", tag, obs, 7'b0100001); end
    step_to(36);
    tests_run++;
    if (obs !== 7'b1100001) begin tests_failed++; $display("FAIL %s_e36 obs=%b exp=%b", tag, obs, 7'b1100001); end
    step_to(45); locked = 2'b11;
    step_to(63);
    tests_run++;
    if (obs !== 7'b1100001) begin tests_failed++; $display("FAIL %s_e63 obs=%b exp=%b", tag, obs, 7'b1100001); end
    step_to(64);
    tests_run++;
    if (obs !== 7'b1111001) begin tests_failed++; $display("FAIL %s_e64 obs=%b exp=%b", tag, obs, 7'b1111001); end
    $display("[TB] test_nominal %s done, failures so far %0d", tag, tests_failed);
  endtask

  task automatic test_timeout();
    apply_reset();
    step_to(67);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL to_e67 obs=%b exp=%b", obs, 7'b0100000); end
    step_to(68);
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL to_e68 obs=%b exp=%b", obs, 7'b0000000); end
    step_to(71);
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL to_e71 obs=%b exp=%b", obs, 7'b0000000); end
    step_to(72);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL to_e72 obs=%b exp=%b", obs, 7'b0100000); end
    step_to(135);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL to_e135 obs=%b exp=%b", obs, 7'b0100000); end
    step_to(136);
    tests_run++;
    if (obs !== 7'b0000100) begin tests_failed++; $display("FAIL to_e136 obs=%b exp=%b", obs, 7'b0000100); end
    locked = 2'b11;
    step_to(160);
    tests_run++;
    if (obs !== 7'b0000100) begin tests_failed++; $display("FAIL to_sticky obs=%b exp=%b", obs, 7'b0000100); end
    $display("[TB] test_timeout done, failures so far %0d", tests_failed);
  endtask

  task automatic test_settle_drop();
    apply_reset();
    step_to(13); locked = 2'b01;
    step_to(20); locked = 2'b00;
    step_to(22);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL sd_e22 obs=%b exp=%b", obs, 7'b0100000); end
    step_to(23); locked = 2'b01;
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL sd_e23 obs=%b exp=%b", obs, 7'b0000000); end
    step_to(26);
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL sd_e26 obs=%b exp=%b", obs, 7'b0000000); end
    step_to(27);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL sd_e27 obs=%b exp=%b", obs, 7'b0100000); end
    $display("[TB] test_settle_drop done, failures so far %0d", tests_failed);
  endtask

  task automatic test_run_loss();
    bring_up();
    locked = 2'b01;
    step_to(66);
    tests_run++;
    if (obs !== 7'b1111001) begin tests_failed++; $display("FAIL rl_e66 obs=%b exp=%b", obs, 7'b1111001); end
    step_to(67);
    tests_run++;
    if ({obs, loss_count} !== {7'b0100001, 8'd1}) begin
      tests_failed++; $display("FAIL rl_e67 obs=%b loss=%0d exp=%b loss=1", obs, loss_count, 7'b0100001);
    end
    locked = 2'b11;
    step_to(71);
    tests_run++;
    if (obs !== 7'b1100001) begin tests_failed++; $display("FAIL rl_e71 obs=%b exp=%b", obs, 7'b1100001); end
    step_to(87);
    tests_run++;
    if (obs !== 7'b1100001) begin tests_failed++; $display("FAIL rl_e87 obs=%b exp=%b", obs, 7'b1100001); end
    step_to(88);
    tests_run++;
    if ({obs, loss_count} !== {7'b1111001, 8'd1}) begin
      tests_failed++; $display("FAIL rl_e88 obs=%b loss=%0d exp=%b loss=1", obs, loss_count, 7'b1111001);
    end
    $display("[TB] test_run_loss done, failures so far %0d", tests_failed);
  endtask

  task automatic test_simultaneous_drop();
    bring_up();
    locked = 2'b00;
    step_to(67);
    tests_run++;
    if ({obs, loss_count} !== {7'b0000000, 8'd1}) begin
      tests_failed++; $display("FAIL sim_e67 obs=%b loss=%0d exp=%b loss=1", obs, loss_count, 7'b0000000);
    end
    locked = 2'b11;
    step_to(71);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL sim_e71 obs=%b exp=%b", obs, 7'b0100000); end
    step_to(92);
    tests_run++;
    if (obs !== 7'b1100001) begin tests_failed++; $display("FAIL sim_e92 obs=%b exp=%b", obs, 7'b1100001); end
    step_to(109);
    tests_run++;
    if (obs !== 7'b1111001) begin tests_failed++; $display("FAIL sim_e109 obs=%b exp=%b", obs, 7'b1111001); end
    $display("[TB] test_simultaneous_drop done, failures so far %0d", tests_failed);
  endtask

  task automatic test_reset_mid_settle();
    apply_reset();
    step_to(13); locked = 2'b01;
    step_to(20);
    tests_run++;
    if (obs !== 7'b0100000) begin tests_failed++; $display("FAIL mid_e20 obs=%b exp=%b", obs, 7'b0100000); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs !== 7'b0000000) begin tests_failed++; $display("FAIL mid_async obs=%b exp=%b", obs, 7'b0000000); end
    $display("[TB] test_reset_mid_settle asserted, failures so far %0d", tests_failed);
    test_nominal("after_mid");
  endtask

  task automatic test_saturation();
    int exp;
    bring_up();
    for (int i = 0; i < 260; i++) begin
      locked = 2'b01;
      step_to(edge_n + 3);
      locked = 2'b11;
      step_to(edge_n + 21);
      exp = (i + 1 > 255) ? 255 : i + 1;
      tests_run++;
      if ({ready, loss_count} !== {1'b1, 8'(exp)}) begin
        tests_failed++;
        $display("FAIL sat_%0d ready=%b loss=%0d exp ready=1 loss=%0d", i, ready, loss_count, exp);
      end
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({obs, loss_count} !== {7'b0000000, 8'd0}) begin
      tests_failed++; $display("FAIL sat_reset obs=%b loss=%0d exp=%b loss=0", obs, loss_count, 7'b0000000);
    end
    $display("[TB] test_saturation done, failures so far %0d", tests_failed);
  endtask

  initial begin
    reset  = 1'b1;
    locked = 2'b00;
    #2;
    test_nominal("first");
    test_timeout();
    test_settle_drop();
    test_run_loss();
    test_simultaneous_drop();
    test_reset_mid_settle();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
